// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port 320x240x8 frame RAM between three requesters: the
// VGA scanout reader, the zoom engine and the host load/store port. Requests
// are serialised through a three-state sequencer (IDLE -> ISSUE -> WAIT_RD),
// and read data comes back with a fixed, cycle-exact latency.
//
// Every output is registered. A request sampled at the edge that ends an
// IDLE cycle shows up as gnt/mem_*/addr_err in the very next cycle.
//
// Ports
//   i_clock                      single clock, rising edge
//   i_reset_n                    asynchronous active-low reset
//   i_vga_req / i_vga_addr       scanout read request (read-only requester)
//   o_vga_gnt / o_vga_rvalid     1-cycle issue pulse / 1-cycle data pulse
//   i_eng_req / i_eng_wr         engine request, wr=1 means write
//   i_eng_addr / i_eng_wdata     engine address and write data
//   o_eng_gnt / o_eng_rvalid     as for vga
//   i_host_req / i_host_wr       host request, wr=1 means write
//   i_host_addr / i_host_wdata   host address and write data
//   o_host_gnt / o_host_rvalid   as for vga
//   o_rdata                      shared read-return data, held until next read
//   o_addr_err                   1-cycle pulse: issued address > MAX_ADDR
//   o_busy                       high whenever the sequencer is not in IDLE
//   o_mem_addr / o_mem_wdata     RAM address and write data
//   o_mem_wren                   RAM write enable
//   i_mem_rdata                  RAM read data, RD_LATENCY cycles after issue
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2,      // legal range 1..3
  parameter int MAX_ADDR   = 76799
) (
  input  logic              i_clock,
  input  logic              i_reset_n,

  input  logic              i_vga_req,
  input  logic [ADDR_W-1:0] i_vga_addr,
  output logic              o_vga_gnt,
  output logic              o_vga_rvalid,

  input  logic              i_eng_req,
  input  logic              i_eng_wr,
  input  logic [ADDR_W-1:0] i_eng_addr,
  input  logic [DATA_W-1:0] i_eng_wdata,
  output logic              o_eng_gnt,
  output logic              o_eng_rvalid,

  input  logic              i_host_req,
  input  logic              i_host_wr,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_gnt,
  output logic              o_host_rvalid,

  output logic [DATA_W-1:0] o_rdata,
  output logic              o_addr_err,
  output logic              o_busy,

  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_VGA  = 2'd0,
    OWN_ENG  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(MAX_ADDR);

  // The WAIT_RD counter starts at RD_LATENCY-1 and captures at zero, which
  // puts the capture edge at the end of cycle issue+RD_LATENCY.
  localparam logic [1:0] LP_CNT_INIT = 2'(RD_LATENCY - 1);

  // Sequencer state and bookkeeping for the transaction in flight
  state_t              r_state;
  owner_t              r_owner;
  logic                r_is_wr;
  logic                r_oob;
  logic [1:0]          r_cnt;

  // Round-robin pointer between engine and host: 1 = engine wins a tie
  logic                r_rr_eng;

  // Registered outputs
  logic                r_vga_gnt;
  logic                r_eng_gnt;
  logic                r_host_gnt;
  logic                r_vga_rvalid;
  logic                r_eng_rvalid;
  logic                r_host_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_addr_err;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_wren;

  // Arbitration results for the current cycle
  logic                w_pick_vga;
  logic                w_pick_eng;
  logic                w_pick_host;
  logic                w_any_req;
  owner_t              w_sel_owner;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_sel_oob;

  // Fixed priority for scanout, round robin between engine and host. The
  // pointer only matters when both of them are asking in the same cycle.
  assign w_pick_vga  = i_vga_req;
  assign w_pick_eng  = !i_vga_req && i_eng_req  && (!i_host_req || r_rr_eng);
  assign w_pick_host = !i_vga_req && i_host_req && (!i_eng_req  || !r_rr_eng);
  assign w_any_req   = i_vga_req || i_eng_req || i_host_req;

  // Route the winner's op, address and data onto one set of wires. The
  // scanout port can only read, so it contributes no write data.
  always_comb begin
    w_sel_owner = OWN_VGA;
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_pick_vga) begin
      w_sel_owner = OWN_VGA;
      w_sel_addr  = i_vga_addr;
    end else if (w_pick_eng) begin
      w_sel_owner = OWN_ENG;
      w_sel_wr    = i_eng_wr;
      w_sel_addr  = i_eng_addr;
      w_sel_wdata = i_eng_wdata;
    end else if (w_pick_host) begin
      w_sel_owner = OWN_HOST;
      w_sel_wr    = i_host_wr;
      w_sel_addr  = i_host_addr;
      w_sel_wdata = i_host_wdata;
    end
  end

  assign w_sel_oob = (w_sel_addr > LP_MAX_ADDR);

  // Sequencer with registered outputs. Grants, strobes and the RAM address
  // are loaded on the edge that leaves IDLE so they are valid throughout
  // the ISSUE cycle; rvalid is loaded on the edge that leaves WAIT_RD so it
  // coincides with the first IDLE cycle. An out-of-range access is still
  // granted, but the RAM sees address 0 with no write strobe, and a read of
  // it returns 0 instead of whatever the RAM produces.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_VGA;
      r_is_wr       <= 1'b0;
      r_oob         <= 1'b0;
      r_cnt         <= '0;
      r_rr_eng      <= 1'b1;
      r_vga_gnt     <= 1'b0;
      r_eng_gnt     <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_vga_rvalid  <= 1'b0;
      r_eng_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_rdata       <= '0;
      r_addr_err    <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wren    <= 1'b0;
    end else begin
      r_vga_rvalid  <= 1'b0;
      r_eng_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state     <= ST_ISSUE;
            r_busy      <= 1'b1;
            r_owner     <= w_sel_owner;
            r_is_wr     <= w_sel_wr;
            r_oob       <= w_sel_oob;
            r_vga_gnt   <= w_pick_vga;
            r_eng_gnt   <= w_pick_eng;
            r_host_gnt  <= w_pick_host;
            r_mem_addr  <= w_sel_oob ? '0 : w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_wren  <= w_sel_wr && !w_sel_oob;
            r_addr_err  <= w_sel_oob;
            // Scanout grants leave the engine/host fairness untouched.
            if (!w_pick_vga) begin
              r_rr_eng <= !r_rr_eng;
            end
          end
        end

        ST_ISSUE: begin
          r_vga_gnt  <= 1'b0;
          r_eng_gnt  <= 1'b0;
          r_host_gnt <= 1'b0;
          r_mem_wren <= 1'b0;
          r_addr_err <= 1'b0;
          if (r_is_wr) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_WAIT_RD;
            r_cnt   <= LP_CNT_INIT;
          end
        end

        ST_WAIT_RD: begin
          if (r_cnt == 2'd0) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_rdata       <= r_oob ? '0 : i_mem_rdata;
            r_vga_rvalid  <= (r_owner == OWN_VGA);
            r_eng_rvalid  <= (r_owner == OWN_ENG);
            r_host_rvalid <= (r_owner == OWN_HOST);
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_vga_gnt     = r_vga_gnt;
  assign o_eng_gnt     = r_eng_gnt;
  assign o_host_gnt    = r_host_gnt;
  assign o_vga_rvalid  = r_vga_rvalid;
  assign o_eng_rvalid  = r_eng_rvalid;
  assign o_host_rvalid = r_host_rvalid;
  assign o_rdata       = r_rdata;
  assign o_addr_err    = r_addr_err;
  assign o_busy        = r_busy;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_mem_wren    = r_mem_wren;

endmodule
